// File: rtl/pipeline_controller.sv
// Stall/flush/halt sequencer for a 5-stage pipeline; enables and flushes are combinational from state and inputs.
// mem_busy freezes every stage and holds all sequencing state; stallCount/flushCount saturate.
module pipeline_controller #(
   parameter int LOAD_BUBBLES = 2,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       id_ra,
   input  logic [3:0]       id_rb,
   input  logic             id_useA,
   input  logic             id_useB,
   input  logic             id_halt,
   input  logic             ex_memToReg,
   input  logic [3:0]       ex_rd,
   input  logic             ex_branchTaken,
   input  logic             mem_busy,
   input  logic             resume,
   output logic             pcEn,
   output logic             ifIdEn,
   output logic             idExEn,
   output logic             exMemEn,
   output logic             memWbEn,
   output logic             ifIdFlush,
   output logic             idExFlush,
   output logic             halted,
   output logic [CNT_W-1:0] stallCount,
   output logic [CNT_W-1:0] flushCount,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      DRAIN      = 2'd2,
      HALTED     = 2'd3
   } state_t;

   localparam int BUB_W   = 2;
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 2);
   localparam logic [BUB_W-1:0]   BUB_LOAD   = BUB_W'(LOAD_BUBBLES - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

   state_t             curState;
   state_t             nextState;
   logic [BUB_W-1:0]   bubCnt;
   logic [BUB_W-1:0]   nextBub;
   logic [DRAIN_W-1:0] drainCnt;
   logic [DRAIN_W-1:0] nextDrain;
   logic               hazard;
   logic               stallFront;
   logic               freezeAll;
   logic               stallInc;
   logic               flushInc;

   assign hazard = ex_memToReg &&
                   ((id_useA && (id_ra == ex_rd)) || (id_useB && (id_rb == ex_rd)));

   always_comb begin
      nextState  = curState;
      nextBub    = bubCnt;
      nextDrain  = drainCnt;
      stallFront = 1'b0;
      freezeAll  = 1'b0;
      stallInc   = 1'b0;
      flushInc   = 1'b0;
      pcEn       = 1'b1;
      ifIdEn     = 1'b1;
      idExEn     = 1'b1;
      exMemEn    = 1'b1;
      memWbEn    = 1'b1;
      ifIdFlush  = 1'b0;
      idExFlush  = 1'b0;

      if (mem_busy) begin
         freezeAll = 1'b1;
         stallInc  = 1'b1;
      end else begin
         unique case (curState)
            RUN: begin
               if (ex_branchTaken) begin
                  ifIdFlush = 1'b1;
                  idExFlush = 1'b1;
                  flushInc  = 1'b1;
               end else if (hazard) begin
                  stallFront = 1'b1;
                  stallInc   = 1'b1;
                  nextBub    = BUB_LOAD;
                  nextState  = (BUB_LOAD != '0) ? LOAD_STALL : RUN;
               end else if (id_halt) begin
                  stallFront = 1'b1;
                  nextDrain  = DRAIN_LOAD;
                  nextState  = (DRAIN_LOAD != '0) ? DRAIN : HALTED;
               end
            end
            LOAD_STALL: begin
               if (ex_branchTaken) begin
                  ifIdFlush = 1'b1;
                  idExFlush = 1'b1;
                  flushInc  = 1'b1;
                  nextBub   = '0;
                  nextState = RUN;
               end else begin
                  stallFront = 1'b1;
                  stallInc   = 1'b1;
                  // Counter of 0 here can only follow a corrupted state; treat it as the last bubble.
                  nextBub    = (bubCnt != '0) ? bubCnt - 1'b1 : '0;
                  if (bubCnt <= BUB_W'(1))
                     nextState = RUN;
               end
            end
            DRAIN: begin
               // Taken branches from stages still draining are irrelevant once fetch has stopped.
               stallFront = 1'b1;
               nextDrain  = (drainCnt != '0) ? drainCnt - 1'b1 : '0;
               if (drainCnt <= DRAIN_W'(1))
                  nextState = HALTED;
            end
            HALTED: begin
               freezeAll = 1'b1;
               if (resume) begin
                  ifIdFlush = 1'b1;
                  nextState = RUN;
               end
            end
            default: nextState = RUN;
         endcase
      end

      if (freezeAll) begin
         pcEn    = 1'b0;
         ifIdEn  = 1'b0;
         idExEn  = 1'b0;
         exMemEn = 1'b0;
         memWbEn = 1'b0;
      end

      if (stallFront) begin
         pcEn      = 1'b0;
         ifIdEn    = 1'b0;
         idExFlush = 1'b1;
      end

      // Reset cycle presents a free-running pipeline regardless of the stale state register.
      if (rst) begin
         pcEn      = 1'b1;
         ifIdEn    = 1'b1;
         idExEn    = 1'b1;
         exMemEn   = 1'b1;
         memWbEn   = 1'b1;
         ifIdFlush = 1'b0;
         idExFlush = 1'b0;
      end
   end

   assign halted = (curState == HALTED) && !rst;
   assign state  = curState;

   always_ff @(posedge clk) begin
      if (rst) begin
         curState   <= RUN;
         bubCnt     <= '0;
         drainCnt   <= '0;
         stallCount <= '0;
         flushCount <= '0;
      end else begin
         curState <= nextState;
         bubCnt   <= nextBub;
         drainCnt <= nextDrain;
         if (stallInc && (stallCount != '1))
            stallCount <= stallCount + 1'b1;
         if (flushInc && (flushCount != '1))
            flushCount <= flushCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench: each driven cycle queues its expected outputs, the negedge monitor pops and compares them.
module tb_pipeline_controller;

   localparam int CNT_W = 4;
   localparam logic [4:0] EN_ALL   = 5'b11111;
   localparam logic [4:0] EN_STALL = 5'b00111;
   localparam logic [4:0] EN_NONE  = 5'b00000;
   localparam logic [1:0] FL_NONE  = 2'b00;
   localparam logic [1:0] FL_IDEX  = 2'b01;
   localparam logic [1:0] FL_IFID  = 2'b10;
   localparam logic [1:0] FL_BOTH  = 2'b11;
   localparam logic [1:0] S_RUN = 2'd0, S_LS = 2'd1, S_DRAIN = 2'd2, S_HALT = 2'd3;

   typedef struct {
      logic       rst;
      logic [3:0] ra, rb, rd;
      logic       useA, useB, halt, memToReg, branch, busy, resume;
   } stim_t;

   typedef struct {
      logic [4:0] en;
      logic [1:0] fl;
      logic       hlt;
      logic [1:0] st;
      int         stall;
      int         flush;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       id_ra, id_rb, ex_rd;
   logic             id_useA, id_useB, id_halt, ex_memToReg, ex_branchTaken, mem_busy, resume;
   logic             pcEn, ifIdEn, idExEn, exMemEn, memWbEn, ifIdFlush, idExFlush, halted;
   logic [CNT_W-1:0] stallCount, flushCount;
   logic [1:0]       state;

   stim_t in;
   exp_t  sbq[$];
   exp_t  monExp;
   int    numChecks = 0;
   int    numPass   = 0;
   int    cycNo     = 0;

   always #5 clk = ~clk;

   pipeline_controller #(
      .LOAD_BUBBLES(2),
      .DRAIN_CYCLES(3),
      .CNT_W       (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .id_ra         (id_ra),
      .id_rb         (id_rb),
      .id_useA       (id_useA),
      .id_useB       (id_useB),
      .id_halt       (id_halt),
      .ex_memToReg   (ex_memToReg),
      .ex_rd         (ex_rd),
      .ex_branchTaken(ex_branchTaken),
      .mem_busy      (mem_busy),
      .resume        (resume),
      .pcEn          (pcEn),
      .ifIdEn        (ifIdEn),
      .idExEn        (idExEn),
      .exMemEn       (exMemEn),
      .memWbEn       (memWbEn),
      .ifIdFlush     (ifIdFlush),
      .idExFlush     (idExFlush),
      .halted        (halted),
      .stallCount    (stallCount),
      .flushCount    (flushCount),
      .state         (state)
   );

   task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      numChecks++;
      if (obs === exp)
         numPass++;
      else
         $display("FAIL %s @cyc %0d: got %0d, want %0d", tag, cycNo, obs, exp);
   endtask

   task automatic idle();
      in.rst = 1'b0; in.ra = 4'd0; in.rb = 4'd0; in.rd = 4'd0;
      in.useA = 1'b0; in.useB = 1'b0; in.halt = 1'b0; in.memToReg = 1'b0;
      in.branch = 1'b0; in.busy = 1'b0; in.resume = 1'b0;
   endtask

   task automatic hazardA();
      idle();
      in.memToReg = 1'b1; in.rd = 4'd5; in.useA = 1'b1; in.ra = 4'd5;
   endtask

   task automatic cyc(input logic [4:0] en, input logic [1:0] fl, input logic hlt,
                      input logic [1:0] st, input int stallE, input int flushE);
      exp_t e;
      rst = in.rst; id_ra = in.ra; id_rb = in.rb; ex_rd = in.rd;
      id_useA = in.useA; id_useB = in.useB; id_halt = in.halt; ex_memToReg = in.memToReg;
      ex_branchTaken = in.branch; mem_busy = in.busy; resume = in.resume;
      e.en = en; e.fl = fl; e.hlt = hlt; e.st = st; e.stall = stallE; e.flush = flushE;
      sbq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         monExp = sbq.pop_front();
         chkVal("enables", {27'd0, pcEn, ifIdEn, idExEn, exMemEn, memWbEn}, {27'd0, monExp.en});
         chkVal("flushes", {30'd0, ifIdFlush, idExFlush}, {30'd0, monExp.fl});
         chkVal("halted", {31'd0, halted}, {31'd0, monExp.hlt});
         chkVal("state", {30'd0, state}, {30'd0, monExp.st});
         chkVal("stallCount", {28'd0, stallCount}, monExp.stall);
         chkVal("flushCount", {28'd0, flushCount}, monExp.flush);
         cycNo++;
      end
   end

   initial begin
      idle();
      in.rst = 1'b1;
      rst = 1'b1; id_ra = '0; id_rb = '0; ex_rd = '0; id_useA = 0; id_useB = 0;
      id_halt = 0; ex_memToReg = 0; ex_branchTaken = 0; mem_busy = 0; resume = 0;
      @(posedge clk);
      #1;
      cyc(EN_ALL, FL_NONE, 0, S_RUN, 0, 0);

      // load-use on Ra: two bubbles then run
      idle();     cyc(EN_ALL,   FL_NONE, 0, S_RUN, 0, 0);
      hazardA();  cyc(EN_STALL, FL_IDEX, 0, S_RUN, 0, 0);
      idle();     cyc(EN_STALL, FL_IDEX, 0, S_LS,  1, 0);
      idle();     cyc(EN_ALL,   FL_NONE, 0, S_RUN, 2, 0);
      idle();     cyc(EN_ALL,   FL_NONE, 0, S_RUN, 2, 0);
      in.rst = 1; cyc(EN_ALL,   FL_NONE, 0, S_RUN, 2, 0);

      // no hazard: unused Ra, mismatched Rb, non-load producer
      hazardA(); in.useA = 0; in.useB = 1; in.rb = 4'd6;
      cyc(EN_ALL, FL_NONE, 0, S_RUN, 0, 0);
      hazardA(); in.memToReg = 0;
      cyc(EN_ALL, FL_NONE, 0, S_RUN, 0, 0);
      idle();    cyc(EN_ALL, FL_NONE, 0, S_RUN, 0, 0);

      // taken branch in second stall cycle
      hazardA();  cyc(EN_STALL, FL_IDEX, 0, S_RUN, 0, 0);
      idle(); in.branch = 1;
      cyc(EN_ALL, FL_BOTH, 0, S_LS, 1, 0);
      idle();     cyc(EN_ALL, FL_NONE, 0, S_RUN, 1, 1);
      in.rst = 1; cyc(EN_ALL, FL_NONE, 0, S_RUN, 1, 1);

      // mem_busy during LOAD_STALL, then busy overriding a branch in RUN
      hazardA();  cyc(EN_STALL, FL_IDEX, 0, S_RUN, 0, 0);
      for (int i = 0; i < 3; i++) begin
         idle(); in.busy = 1;
         cyc(EN_NONE, FL_NONE, 0, S_LS, 1 + i, 0);
      end
      idle();     cyc(EN_STALL, FL_IDEX, 0, S_LS,  4, 0);
      idle();     cyc(EN_ALL,   FL_NONE, 0, S_RUN, 5, 0);
      idle(); in.busy = 1; in.branch = 1;
      cyc(EN_NONE, FL_NONE, 0, S_RUN, 5, 0);
      idle();     cyc(EN_ALL,   FL_NONE, 0, S_RUN, 6, 0);
      in.rst = 1; cyc(EN_ALL,   FL_NONE, 0, S_RUN, 6, 0);

      // halt, drain (branch and resume ignored), halted, resume
      idle(); in.halt = 1;   cyc(EN_STALL, FL_IDEX, 0, S_RUN,   0, 0);
      idle(); in.halt = 1;   cyc(EN_STALL, FL_IDEX, 0, S_DRAIN, 0, 0);
      idle(); in.branch = 1; cyc(EN_STALL, FL_IDEX, 0, S_DRAIN, 0, 0);
      idle(); in.resume = 1; cyc(EN_STALL, FL_IDEX, 0, S_DRAIN, 0, 0);
      idle();                cyc(EN_NONE,  FL_NONE, 1, S_HALT,  0, 0);
      idle(); in.busy = 1;   cyc(EN_NONE,  FL_NONE, 1, S_HALT,  0, 0);
      idle();                cyc(EN_NONE,  FL_NONE, 1, S_HALT,  1, 0);
      idle(); in.resume = 1; cyc(EN_NONE,  FL_IFID, 1, S_HALT,  1, 0);
      idle();                cyc(EN_ALL,   FL_NONE, 0, S_RUN,   1, 0);

      // reset abandoning DRAIN and LOAD_STALL, and reset beating mem_busy
      idle(); in.halt = 1;   cyc(EN_STALL, FL_IDEX, 0, S_RUN,   1, 0);
      idle();                cyc(EN_STALL, FL_IDEX, 0, S_DRAIN, 1, 0);
      idle(); in.rst = 1;    cyc(EN_ALL,   FL_NONE, 0, S_DRAIN, 1, 0);
      idle();                cyc(EN_ALL,   FL_NONE, 0, S_RUN,   0, 0);
      hazardA();             cyc(EN_STALL, FL_IDEX, 0, S_RUN,   0, 0);
      idle(); in.rst = 1;    cyc(EN_ALL,   FL_NONE, 0, S_LS,    1, 0);
      idle();                cyc(EN_ALL,   FL_NONE, 0, S_RUN,   0, 0);
      hazardA(); in.busy = 1; in.rst = 1;
      cyc(EN_ALL, FL_NONE, 0, S_RUN, 0, 0);
      idle();                cyc(EN_ALL,   FL_NONE, 0, S_RUN,   0, 0);

      // branch outranks hazard; Rb hazard outranks halt
      hazardA(); in.branch = 1;
      cyc(EN_ALL, FL_BOTH, 0, S_RUN, 0, 0);
      idle();    cyc(EN_ALL, FL_NONE, 0, S_RUN, 0, 1);
      idle(); in.memToReg = 1; in.rd = 4'd9; in.useB = 1; in.rb = 4'd9;
      in.useA = 1; in.ra = 4'd3; in.halt = 1;
      cyc(EN_STALL, FL_IDEX, 0, S_RUN, 0, 1);
      idle();     cyc(EN_STALL, FL_IDEX, 0, S_LS,  1, 1);
      idle();     cyc(EN_ALL,   FL_NONE, 0, S_RUN, 2, 1);
      in.rst = 1; cyc(EN_ALL,   FL_NONE, 0, S_RUN, 2, 1);

      // saturation of both 4-bit counters
      for (int i = 0; i < 20; i++) begin
         idle(); in.busy = 1;
         cyc(EN_NONE, FL_NONE, 0, S_RUN, (i > 15) ? 15 : i, 0);
      end
      idle();     cyc(EN_ALL, FL_NONE, 0, S_RUN, 15, 0);
      in.rst = 1; cyc(EN_ALL, FL_NONE, 0, S_RUN, 15, 0);
      for (int i = 0; i < 20; i++) begin
         idle(); in.branch = 1;
         cyc(EN_ALL, FL_BOTH, 0, S_RUN, 0, (i > 15) ? 15 : i);
      end
      idle();     cyc(EN_ALL, FL_NONE, 0, S_RUN, 0, 15);

      for (int i = 0; i < 4 && sbq.size() != 0; i++)
         @(negedge clk);
      #1;
      chkVal("scoreboard_empty", sbq.size(), 0);
      $display("%0d/%0d checks passed", numPass, numChecks);
      $finish;
   end

endmodule
